char_gen_stream: RTL and testbench
==================================

# char_gen_stream

Parametrised successor to the bruteforce character generator. It enumerates every word of length `max_characters+1` over a `charset_size`-symbol alphabet in reflected mixed-radix Gray order, so consecutive words differ in exactly one character by ±1. It emits one (offset, character) update per accepted word on a valid/ready stream, which allows hash cores to stall it. It sits between the host configuration registers and the message-patching front end of each hash pipeline.

## Interface
Parameters:
- `MAX_CHARS`, 16: number of digit registers; maximum bruteforced word length.
- `PTR_W`, 4: width of `max_characters`; equals clog2(`MAX_CHARS`).
- `CHAR_W`, 7: width of digits, `charset_size`, `char_base` and `char_out`.
- `OFF_W`, 6: width of `start_offset` and `offset_out`.
- `CNT_W`, 49: width of `word_counter` and `word_limit`.

Ports:
- `clk` in 1: clock. One clock domain; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; latches the configuration and begins enumeration.
- `start_offset` in OFF_W: message byte position of digit 0.
- `max_characters` in PTR_W: word length minus 1 (N = value+1).
- `charset_size` in CHAR_W: radix R.
- `char_base` in CHAR_W: added to the digit to form `char_out`.
- `word_limit` in CNT_W: stop after this many updates; 0 means unlimited.
- `upd_valid` out 1: an update is presented.
- `upd_ready` in 1: the consumer accepts the update.
- `offset_out` out OFF_W: byte position being changed.
- `char_out` out CHAR_W: new character value.
- `word_counter` out CNT_W: index of the word produced by the presented update (first update = 1).
- `busy` out 1: the block is in RUN.
- `finished` out 1: enumeration is complete.

## Operation
- States:
  - IDLE: after reset.
  - RUN.
  - DONE.
- Reset: state IDLE. All outputs are 0: `upd_valid`, `busy`, `finished`, `offset_out`, `char_out`, `word_counter`. Digits and direction bits are cleared.
- Leaving IDLE or DONE on `start`:
  - Latch `start_offset`, `max_characters`, `charset_size`, `char_base` and `word_limit`.
  - Clear all digits d[i] and direction bits dir[i] (0 = up).
  - Clear `finished` and `word_counter`.
  - `start` is ignored while in RUN.
- Step rule, applied to the current word:
  - Find the lowest i < N where d[i] is not at its bound. The bound is R-1 when dir[i]=0, and 0 when dir[i]=1.
  - Set d[i] = d[i] + 1 (dir 0) or d[i] - 1 (dir 1).
  - Toggle dir[j] for every j < i.
  - The update is `offset_out` = `start_offset` + i (mod 2^OFF_W) and `char_out` = d[i] + `char_base` (mod 2^CHAR_W).
  - If no such i exists, the enumeration is exhausted.
- Transitions:
  - On entry to RUN, the first step is presented with `word_counter`=1.
  - On each `upd_valid & upd_ready`, the next step is presented and `word_counter` increments by 1.
  - When the accepted update is the last one, the block enters DONE. An update is last when the enumeration is exhausted after it, or when `word_counter` == `word_limit` and `word_limit` != 0.
  - If `charset_size` < 2, the block goes directly from IDLE to DONE with no update.
- DONE: `upd_valid`=0, `busy`=0, `finished`=1. The block holds until `reset` or `start`. `word_counter` keeps the last index.
- The total number of updates is min(R^N - 1, `word_limit`) when `word_limit` is nonzero, and R^N - 1 otherwise. Digits never leave the range 0..R-1.
- Configuration inputs are sampled only on `start`; changes during RUN have no effect.

## Timing
- Latency: `start` at cycle t gives `upd_valid`=1 and `busy`=1 at t+1.
- Throughput: one update per cycle while `upd_ready` is held high.
- Stall: while `upd_valid=1` and `upd_ready=0`, `offset_out`, `char_out` and `word_counter` hold stable. `upd_valid` never drops without a handshake.
- Completion: the handshake of the last update at cycle t gives `upd_valid`=0 and `finished`=1 at t+1.
- `reset` has priority over everything, in any state and mid-stall. The outputs return to their reset values on the next edge.
- `start` and `reset` asserted together: `reset` wins; the block stays in IDLE.
- The step logic is a priority encode over `MAX_CHARS` digits plus one CHAR_W add, and must close in a single cycle. It is registered into the output regs on each handshake.

## Test plan
- Full sequence: R=3, N=2 (`max_characters`=1), `start_offset`=10, `char_base`=0x41, `upd_ready`=1.
  - Required (offset, char) sequence: (10,0x42), (10,0x43), (11,0x42), (10,0x42), (10,0x41), (11,0x43), (10,0x42), (10,0x43).
  - `word_counter` runs 1..8; `finished`=1 one cycle after the 8th update.
- Backpressure: same configuration, `upd_ready` random at 30%.
  - Same 8 updates in the same order, with no duplicates or drops.
  - Outputs are stable throughout every stall.
- Word limit: R=4, N=3, `word_limit`=5.
  - Exactly 5 updates: offset 0 with digit 1,2,3, then offset 1 with digit 1, then offset 0 with digit 2.
  - Then DONE, with `word_counter`=5.
- Degenerate configurations:
  - `charset_size`=1: `finished`=1 at t+2 with `upd_valid` never asserted.
  - `charset_size`=2, N=1: a single update (0,1), then DONE.
- Reset and restart:
  - `reset` asserted mid-stall in RUN: all outputs are 0 on the next cycle.
  - `start` in DONE: the enumeration restarts from `word_counter`=1.
  - `start` pulsed during RUN: no effect on the stream.
- Exhaustive check: R=5, N=4 against a reference model.
  - 624 updates; every word is visited exactly once.
  - Each update changes exactly one digit by ±1.

Source files
------------

// File: rtl/char_gen_stream.sv
// rtl/char_gen_stream.sv - reflected mixed-radix Gray word enumerator emitting (offset, char) updates
module char_gen_stream #(
  parameter int MAX_CHARS = 16,
  parameter int PTR_W     = 4,
  parameter int CHAR_W    = 7,
  parameter int OFF_W     = 6,
  parameter int CNT_W     = 49
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OFF_W-1:0]  start_offset,
  input  logic [PTR_W-1:0]  max_characters,
  input  logic [CHAR_W-1:0] charset_size,
  input  logic [CHAR_W-1:0] char_base,
  input  logic [CNT_W-1:0]  word_limit,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [OFF_W-1:0]  offset_out,
  output logic [CHAR_W-1:0] char_out,
  output logic [CNT_W-1:0]  word_counter,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CHAR_W-1:0]  digit [MAX_CHARS];
  logic [MAX_CHARS-1:0] dir;
  logic [OFF_W-1:0]   off_q;
  logic [PTR_W-1:0]   nmax_q;
  logic [CHAR_W-1:0]  radix_q;
  logic [CHAR_W-1:0]  base_q;
  logic [CNT_W-1:0]   limit_q;
  logic               empty_pending;

  logic               step_found;
  logic [PTR_W-1:0]   step_idx;
  logic [CHAR_W-1:0]  step_digit;
  logic               last_accept;

  // Lowest active digit not yet at its bound in its current direction.
  always_comb begin
    step_found = 1'b0;
    step_idx   = '0;
    for (int i = MAX_CHARS - 1; i >= 0; i--) begin
      if (PTR_W'(i) <= nmax_q &&
          (dir[i] ? (digit[i] != '0) : (digit[i] != radix_q - CHAR_W'(1)))) begin
        step_found = 1'b1;
        step_idx   = PTR_W'(i);
      end
    end
    step_digit  = dir[step_idx] ? digit[step_idx] - CHAR_W'(1) : digit[step_idx] + CHAR_W'(1);
    last_accept = !step_found || (limit_q != '0 && word_counter == limit_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      upd_valid     <= 1'b0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      offset_out    <= '0;
      char_out      <= '0;
      word_counter  <= '0;
      dir           <= '0;
      off_q         <= '0;
      nmax_q        <= '0;
      radix_q       <= '0;
      base_q        <= '0;
      limit_q       <= '0;
      empty_pending <= 1'b0;
      for (int i = 0; i < MAX_CHARS; i++) digit[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            off_q         <= start_offset;
            nmax_q        <= max_characters;
            radix_q       <= charset_size;
            base_q        <= char_base;
            limit_q       <= word_limit;
            dir           <= '0;
            finished      <= 1'b0;
            word_counter  <= '0;
            empty_pending <= 1'b0;
            for (int i = 0; i < MAX_CHARS; i++) digit[i] <= '0;
            if (charset_size < CHAR_W'(2)) begin
              // No words to emit; report completion on the following cycle.
              state         <= IDLE;
              empty_pending <= 1'b1;
            end else begin
              // First step from the all-zero word always raises digit 0 to 1.
              state        <= RUN;
              busy         <= 1'b1;
              upd_valid    <= 1'b1;
              digit[0]     <= CHAR_W'(1);
              offset_out   <= start_offset;
              char_out     <= char_base + CHAR_W'(1);
              word_counter <= CNT_W'(1);
            end
          end else if (state == IDLE && empty_pending) begin
            state         <= DONE;
            finished      <= 1'b1;
            empty_pending <= 1'b0;
          end
        end
        RUN: begin
          if (upd_valid && upd_ready) begin
            if (last_accept) begin
              state     <= DONE;
              upd_valid <= 1'b0;
              busy      <= 1'b0;
              finished  <= 1'b1;
            end else begin
              digit[step_idx] <= step_digit;
              for (int j = 0; j < MAX_CHARS; j++)
                dir[j] <= dir[j] ^ (PTR_W'(j) < step_idx);
              offset_out   <= off_q + OFF_W'(step_idx);
              char_out     <= step_digit + base_q;
              word_counter <= word_counter + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_gen_stream.sv
// tb/tb_char_gen_stream.sv - randomized-backpressure bench for char_gen_stream against an arithmetic Gray model
module tb_char_gen_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  start_offset = '0;
  logic [3:0]  max_characters = '0;
  logic [6:0]  charset_size = '0;
  logic [6:0]  char_base = '0;
  logic [48:0] word_limit = '0;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [5:0]  offset_out;
  logic [6:0]  char_out;
  logic [48:0] word_counter;
  logic        busy;
  logic        finished;

  int checks = 0;
  int errors = 0;

  char_gen_stream dut (
    .clk(clk), .reset(reset), .start(start), .start_offset(start_offset),
    .max_characters(max_characters), .charset_size(charset_size), .char_base(char_base),
    .word_limit(word_limit), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .offset_out(offset_out), .char_out(char_out), .word_counter(word_counter),
    .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ipow(input int b, input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r *= b;
    return r;
  endfunction

  // Digit i of the k-th word: base-R digit of k, mirrored when the count of higher-digit steps is odd.
  function automatic int gdig(input int k, input int i, input int r);
    int q;
    int v;
    q = k / ipow(r, i);
    v = q % r;
    if (((q / r) % 2) == 1) v = r - 1 - v;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, upd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_offset"}, offset_out, 0);
    check({tag, "_char"}, char_out, 0);
    check({tag, "_count"}, word_counter, 0);
  endtask

  task automatic do_start(input int r, input int n, input int off, input int base, input int limit);
    start_offset   = 6'(off);
    max_characters = 4'(n - 1);
    charset_size   = 7'(r);
    char_base      = 7'(base);
    word_limit     = 49'(limit);
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  task automatic run_stream(input int r, input int n, input int off, input int base, input int limit,
                            input int pct, input bit use_table, input bit pulse_start);
    int total, cnt, cyc, ei, di, dv, delta, w;
    bit stalled, pulsed;
    logic [5:0]  s_off;
    logic [6:0]  s_chr;
    logic [48:0] s_cnt;
    int cur [16];
    bit visited [0:1023];
    int tab_off [8];
    int tab_chr [8];
    tab_off = '{10, 10, 11, 10, 10, 11, 10, 10};
    tab_chr = '{8'h42, 8'h43, 8'h42, 8'h42, 8'h41, 8'h43, 8'h42, 8'h43};
    for (int i = 0; i < 16; i++) cur[i] = 0;
    for (int i = 0; i < 1024; i++) visited[i] = 1'b0;
    visited[0] = 1'b1;
    total = ipow(r, n) - 1;
    if (limit != 0 && limit < total) total = limit;
    cnt = 0; cyc = 0; stalled = 0; pulsed = 0;
    s_off = '0; s_chr = '0; s_cnt = '0;
    check("latency_busy", busy, 1);
    while (cnt < total && cyc < 5000) begin
      cyc++;
      check("valid_held", upd_valid, 1);
      if (stalled) begin
        check("stall_offset", offset_out, s_off);
        check("stall_char", char_out, s_chr);
        check("stall_count", word_counter, s_cnt);
      end
      start = 1'b0;
      if (pulse_start && !pulsed && cnt >= 2) begin
        start = 1'b1; charset_size = 7'd2; start_offset = 6'd33; word_limit = 49'd1;
        pulsed = 1;
      end
      upd_ready = ($urandom_range(99) < pct);
      if (upd_valid && upd_ready) begin
        ei = 0;
        for (int i = 0; i < n; i++) if (gdig(cnt + 1, i, r) != gdig(cnt, i, r)) ei = i;
        check("offset", offset_out, 64'((off + ei) % 64));
        check("char", char_out, 64'((base + gdig(cnt + 1, ei, r)) % 128));
        check("count", word_counter, 64'(cnt + 1));
        if (use_table && cnt < 8) begin
          check("table_offset", offset_out, 64'(tab_off[cnt]));
          check("table_char", char_out, 64'(tab_chr[cnt]));
        end
        di = (int'(offset_out) - off) & 63;
        dv = (int'(char_out) - base) & 127;
        check("digit_in_range", (di < n) && (dv < r), 1);
        if (di < n && dv < r) begin
          delta = dv - cur[di];
          check("step_pm1", (delta == 1) || (delta == -1), 1);
          cur[di] = dv;
          w = 0;
          for (int i = n - 1; i >= 0; i--) w = w * r + cur[i];
          if (w < 1024) begin
            check("word_fresh", visited[w], 0);
            visited[w] = 1'b1;
          end
        end
        cnt++;
        stalled = 0;
      end else begin
        stalled = 1;
        s_off = offset_out; s_chr = char_out; s_cnt = word_counter;
      end
      @(negedge clk);
    end
    start = 1'b0;
    upd_ready = 1'b0;
    check("update_total", cnt, total);
    check("done_valid", upd_valid, 0);
    check("done_finished", finished, 1);
    check("done_busy", busy, 0);
    check("done_count", word_counter, 64'(total));
    repeat (2) @(negedge clk);
    check("done_hold_valid", upd_valid, 0);
    check("done_hold_finished", finished, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_valid", upd_valid, 0);

    do_start(3, 2, 10, 8'h41, 0);
    run_stream(3, 2, 10, 8'h41, 0, 100, 1, 0);

    do_start(3, 2, 10, 8'h41, 0);
    check("restart_count", word_counter, 1);
    run_stream(3, 2, 10, 8'h41, 0, 30, 1, 0);

    do_start(4, 3, 0, 0, 5);
    run_stream(4, 3, 0, 0, 5, 60, 0, 0);

    do_start(2, 1, 0, 0, 0);
    run_stream(2, 1, 0, 0, 0, 50, 0, 0);

    upd_ready = 1'b1;
    do_start(1, 3, 0, 0, 0);
    check("r1_t1_valid", upd_valid, 0);
    check("r1_t1_finished", finished, 0);
    @(negedge clk);
    check("r1_t2_valid", upd_valid, 0);
    check("r1_t2_finished", finished, 1);
    check("r1_t2_count", word_counter, 0);
    upd_ready = 1'b0;

    do_start(3, 2, 7, 8'h30, 0);
    repeat (3) @(negedge clk);
    check("stall_before_reset", upd_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midstall_reset");

    reset = 1'b1;
    do_start(3, 2, 7, 8'h30, 0);
    reset = 1'b0;
    check("reset_start_valid", upd_valid, 0);
    check("reset_start_busy", busy, 0);
    @(negedge clk);
    check("reset_start_idle", busy, 0);

    do_start(5, 4, 20, 8'h61, 0);
    run_stream(5, 4, 20, 8'h61, 0, 70, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
